// File: rtl/alu_mdu_pipe_pkg.sv
// ============================================================================
// alu_mdu_pipe_pkg : ALU function codes and EX-stage FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_mdu_pipe_pkg;

  localparam int FUNCT_W = 5;

  localparam logic [FUNCT_W-1:0] ALU_ADDU  = 5'd0;
  localparam logic [FUNCT_W-1:0] ALU_AND   = 5'd1;
  localparam logic [FUNCT_W-1:0] ALU_NOR   = 5'd2;
  localparam logic [FUNCT_W-1:0] ALU_OR    = 5'd3;
  localparam logic [FUNCT_W-1:0] ALU_SLL   = 5'd4;
  localparam logic [FUNCT_W-1:0] ALU_SRA   = 5'd5;
  localparam logic [FUNCT_W-1:0] ALU_SRL   = 5'd6;
  localparam logic [FUNCT_W-1:0] ALU_SUBU  = 5'd7;
  localparam logic [FUNCT_W-1:0] ALU_XOR   = 5'd8;
  localparam logic [FUNCT_W-1:0] ALU_SLT   = 5'd9;
  localparam logic [FUNCT_W-1:0] ALU_SLTU  = 5'd10;
  localparam logic [FUNCT_W-1:0] ALU_EQ    = 5'd11;
  localparam logic [FUNCT_W-1:0] ALU_NEQ   = 5'd12;
  localparam logic [FUNCT_W-1:0] ALU_LUI   = 5'd13;
  localparam logic [FUNCT_W-1:0] ALU_MULT  = 5'd14;
  localparam logic [FUNCT_W-1:0] ALU_MULTU = 5'd15;
  localparam logic [FUNCT_W-1:0] ALU_DIV   = 5'd16;
  localparam logic [FUNCT_W-1:0] ALU_DIVU  = 5'd17;
  localparam logic [FUNCT_W-1:0] ALU_MFHI  = 5'd18;
  localparam logic [FUNCT_W-1:0] ALU_MFLO  = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

  function automatic logic is_md_op(input logic [FUNCT_W-1:0] f);
    return (f == ALU_MULT) || (f == ALU_MULTU) || (f == ALU_DIV) || (f == ALU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [FUNCT_W-1:0] f);
    return (f == ALU_DIV) || (f == ALU_DIVU);
  endfunction

  function automatic logic is_signed_md_op(input logic [FUNCT_W-1:0] f);
    return (f == ALU_MULT) || (f == ALU_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mdu_pipe_if.sv
// ============================================================================
// alu_mdu_pipe_if : issue/result handshake bundle between decode, EX and WB
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_mdu_pipe_if
  import alu_mdu_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) ();

  logic                kill;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    operand1;
  logic [WIDTH-1:0]    operand2;
  logic [SHAMT_W-1:0]  shamt;
  logic [FUNCT_W-1:0]  funct;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    alu_result;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;

  modport slave (
    input  kill, in_valid, operand1, operand2, shamt, funct, out_ready,
    output in_ready, out_valid, alu_result, hi, lo
  );

  modport master (
    output kill, in_valid, operand1, operand2, shamt, funct, out_ready,
    input  in_ready, out_valid, alu_result, hi, lo
  );

endinterface

`default_nettype wire

// File: rtl/alu_mdu_pipe_md_iter.sv
// ============================================================================
// alu_mdu_pipe_md_iter : one-bit-per-cycle shift-add multiplier / restoring divider
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mdu_pipe_md_iter
  import alu_mdu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic             div_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_neg = signed_op & op_a[WIDTH-1];
  assign b_neg = signed_op & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Multiply: low half holds the remaining multiplier bits, shifted out LSB-first.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: shifted partial remainder needs one extra bit before the trial subtract.
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
  assign div_next = {(div_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  // done marks the cycle in which the final iteration is being computed.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST_ITER);

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    op1_d  = op1_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = {{WIDTH{1'b0}}, a_mag};
      opb_d  = b_mag;
      op1_d  = op_a;
      div_d  = div_op;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = div_op && (op_b == '0);
    end else if (busy_q) begin
      acc_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opb_q  <= '0;
      op1_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      op1_q  <= op1_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quo_s  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_n   = prod_s[2*WIDTH-1:WIDTH];
    lo_n   = prod_s[WIDTH-1:0];
    if (div_q) begin
      if (dz_q) begin
        hi_n = op1_q;
        lo_n = '1;
      end else begin
        hi_n = rem_s;
        lo_n = quo_s;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mdu_pipe.sv
// ============================================================================
// alu_mdu_pipe : EX-stage ALU with iterative multiply/divide and HI/LO registers
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mdu_pipe
  import alu_mdu_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  alu_mdu_pipe_if.slave      bus
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               in_ready, accept, pop;
  logic               md_start, md_busy, md_done;
  logic [WIDTH-1:0]   md_hi, md_lo;
  logic               fin_write;
  logic [WIDTH-1:0]   hi_fwd, lo_fwd;
  logic [WIDTH-1:0]   base_res;

  assign op_a  = bus.operand1;
  assign op_b  = bus.operand2;
  assign shamt = bus.shamt;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.kill;
  assign pop      = out_valid_q && bus.out_ready;
  assign md_start = accept && is_md_op(bus.funct);

  // MFHI/MFLO see a HI/LO write landing on the same edge.
  assign fin_write = (state_q == FIN) && !bus.kill;
  assign hi_fwd    = fin_write ? md_hi : hi_q;
  assign lo_fwd    = fin_write ? md_lo : lo_q;

  alu_mdu_pipe_md_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_md_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .abort     (bus.kill),
    .signed_op (is_signed_md_op(bus.funct)),
    .div_op    (is_div_op(bus.funct)),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (md_busy),
    .done      (md_done),
    .hi_n      (md_hi),
    .lo_n      (md_lo)
  );

  always_comb begin
    base_res = '0;
    case (bus.funct)
      ALU_ADDU: base_res = op_a + op_b;
      ALU_AND:  base_res = op_a & op_b;
      ALU_NOR:  base_res = ~(op_a | op_b);
      ALU_OR:   base_res = op_a | op_b;
      ALU_SLL:  base_res = op_b << shamt;
      ALU_SRA:  base_res = $unsigned($signed(op_b) >>> shamt);
      ALU_SRL:  base_res = op_b >> shamt;
      ALU_SUBU: base_res = op_a - op_b;
      ALU_XOR:  base_res = op_a ^ op_b;
      ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_EQ:   base_res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      ALU_NEQ:  base_res = {{(WIDTH-1){1'b0}}, (op_a != op_b)};
      ALU_LUI:  base_res = op_b << (WIDTH / 2);
      ALU_MFHI: base_res = hi_fwd;
      ALU_MFLO: base_res = lo_fwd;
      default:  base_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (pop) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_md_op(bus.funct)) begin
            state_d = is_div_op(bus.funct) ? DIV : MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = base_res;
          end
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          state_d = FIN;
        end else if (!md_busy) begin
          state_d = IDLE;
        end
      end
      FIN: begin
        state_d     = IDLE;
        hi_d        = md_hi;
        lo_d        = md_lo;
        result_d    = md_lo;
        out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Flush drops the in-flight op without touching architectural state.
    if (bus.kill) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

endmodule

`default_nettype wire
